vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  VGA raster timing generator clocked by the 25.175 MHz pixel clock from the vpg PLL (outclk_0).
//  Waits for PLL lock, then produces hsync, vsync, data-enable, pixel x/y and frame/line strobes.
//  Downstream pattern/framebuffer logic and the DAC/encoder pads consume these signals.
// PARAMETERS
//  H_ACTIVE   640  visible pixels per line
//  H_FP       16   horizontal front porch (pixels)
//  H_SYNC     96   hsync width (pixels)
//  H_BP       48   horizontal back porch (pixels); H_TOTAL = sum = 800
//  V_ACTIVE   480  visible lines per frame
//  V_FP       10   vertical front porch (lines)
//  V_SYNC     2    vsync width (lines)
//  V_BP       33   vertical back porch (lines); V_TOTAL = sum = 525
//  HS_POL     0    hsync active level (0 = active-low)
//  VS_POL     0    vsync active level (0 = active-low)
//  CNT_W      11   width of the internal h/v counters (holds H_TOTAL-1 and V_TOTAL-1)
// PORTS
//  refclk       in   1      pixel clock (PLL outclk_0)
//  rst          in   1      synchronous active-high reset
//  pll_locked   in   1      PLL locked (asynchronous to refclk; synchronized internally)
//  hsync        out  1      horizontal sync, polarity HS_POL
//  vsync        out  1      vertical sync, polarity VS_POL
//  de           out  1      active video (pixel valid)
//  pix_x        out  CNT_W  h counter value (0..H_TOTAL-1; meaningful while de=1)
//  pix_y        out  CNT_W  v counter value (0..V_TOTAL-1)
//  frame_start  out  1      1-cycle pulse at h=0, v=0
//  line_start   out  1      1-cycle pulse at h=0 of every line, including blanking lines
// BEHAVIOUR
//  - Reset applies while rst=1 at a refclk edge. State=WAIT_LOCK; sync flops=0; counters=0.
//    Outputs: hsync=~HS_POL, vsync=~VS_POL, de=0, pix_x=0, pix_y=0, frame_start=0, line_start=0.
//  - pll_locked passes through a 2-flop synchronizer: lock_s rises 2 refclk edges after the input rises.
//  - FSM WAIT_LOCK: counters are held at 0 and outputs at their reset values.
//    On lock_s=1 -> RUN with h=0, v=0.
//  - FSM RUN: h increments every cycle. At h=H_TOTAL-1, h wraps to 0 and v increments.
//    At h=H_TOTAL-1 and v=V_TOTAL-1, both counters wrap to 0.
//  - RUN -> WAIT_LOCK when lock_s=0. Counters clear on that same edge; outputs return to reset values
//    one cycle later. The frame is abandoned mid-line and no partial-frame recovery is attempted.
//  - Outputs are registered from the counter state, so output latency is 1 cycle.
//    The first output cycle after entering RUN shows pix_x=0, pix_y=0, de=1, frame_start=1, line_start=1.
//  - de=1 iff h<H_ACTIVE and v<V_ACTIVE.
//  - hsync is active iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (active for h=656..751).
//  - vsync is active iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (active for lines 490..491).
//    vsync edges are line-aligned and coincide with h=0 outputs.
//  - pix_x/pix_y are the raw counters. Consumers gate them with de.
//  - Comparisons are unsigned, CNT_W bits. Parameters must keep H_TOTAL-1 and V_TOTAL-1 < 2**CNT_W.
//  - If rst and a lock loss occur together, rst wins; the result is identical to reset.
//  - Reset mid-frame: on the next edge after rst falls, the block is in WAIT_LOCK. The synchronizer is
//    cleared, so RUN resumes 2 edges after rst deasserts when pll_locked is steadily 1.
// TESTING
//  1. pll_locked=1 from the start, rst for 4 cycles -> first frame_start exactly 3 cycles after rst falls;
//     pix_x=0, pix_y=0, de=1 on that cycle.
//  2. Free-run 2 frames -> frame_start period 420000 cycles; line_start period 800 cycles;
//     525 line_start pulses per frame.
//  3. Per frame: 307200 cycles with de=1. Per active line: de=1 for 640 consecutive cycles, pix_x 0..639.
//  4. hsync=0 for 96 cycles, starting at the output cycle with pix_x=656.
//     vsync=0 for exactly 1600 cycles, starting with pix_y=490, pix_x=0.
//  5. Drop pll_locked at pix_y=100, pix_x=300 -> reset-value outputs within 4 cycles.
//     Re-raise pll_locked -> new frame_start 3 cycles later with pix_x=0, pix_y=0.
//  6. Pulse rst for 1 cycle at pix_y=200 with pll_locked=1 -> outputs idle; frame_start 3 cycles after rst falls.
//     With HS_POL=1 and VS_POL=1 the idle and active sync levels are inverted versus scenarios 1-4.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: waits for PLL lock, then emits sync, data-enable,
// pixel coordinates and frame/line strobes, all registered one cycle after the counters.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter logic        HS_POL   = 1'b0,
    parameter logic        VS_POL   = 1'b0,
    parameter int unsigned CNT_W    = 11
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             pll_locked,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             frame_start,
    output logic             line_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] ZERO_C     = '0;
    localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);
    localparam logic [CNT_W-1:0] H_LAST_C   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST_C   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_C    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START_C = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END_C   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START_C = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END_C   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [0:0] {
        ST_WAIT_LOCK = 1'b0,
        ST_RUN       = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       sync_q;
    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;
    logic             lock_s;
    logic             run_s;

    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             de_q, de_d;
    logic [CNT_W-1:0] pix_x_q, pix_x_d;
    logic [CNT_W-1:0] pix_y_q, pix_y_d;
    logic             frame_start_q, frame_start_d;
    logic             line_start_q, line_start_d;

    assign lock_s = sync_q[1];
    assign run_s  = (state_q == ST_RUN);

    // Next-state and raster counter advance; losing lock abandons the frame at once.
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        case (state_q)
            ST_WAIT_LOCK: begin
                h_d = ZERO_C;
                v_d = ZERO_C;
                if (lock_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    h_d     = ZERO_C;
                    v_d     = ZERO_C;
                end else if (h_q == H_LAST_C) begin
                    h_d = ZERO_C;
                    if (v_q == V_LAST_C) begin
                        v_d = ZERO_C;
                    end else begin
                        v_d = v_q + ONE_C;
                    end
                end else begin
                    h_d = h_q + ONE_C;
                end
            end
            default: begin
                state_d = ST_WAIT_LOCK;
                h_d     = ZERO_C;
                v_d     = ZERO_C;
            end
        endcase
    end

    // Output decode from the current counters; idle levels whenever not running.
    always_comb begin
        de_d          = 1'b0;
        hsync_d       = ~HS_POL;
        vsync_d       = ~VS_POL;
        pix_x_d       = ZERO_C;
        pix_y_d       = ZERO_C;
        frame_start_d = 1'b0;
        line_start_d  = 1'b0;
        if (run_s) begin
            de_d          = (h_q < H_ACT_C) && (v_q < V_ACT_C);
            hsync_d       = ((h_q >= HS_START_C) && (h_q < HS_END_C)) ? HS_POL : ~HS_POL;
            vsync_d       = ((v_q >= VS_START_C) && (v_q < VS_END_C)) ? VS_POL : ~VS_POL;
            pix_x_d       = h_q;
            pix_y_d       = v_q;
            frame_start_d = (h_q == ZERO_C) && (v_q == ZERO_C);
            line_start_d  = (h_q == ZERO_C);
        end else begin
            de_d = 1'b0;
        end
    end

    // Lock synchronizer, FSM, counters and registered outputs.
    always_ff @(posedge refclk) begin
        if (rst) begin
            sync_q        <= 2'b00;
            state_q       <= ST_WAIT_LOCK;
            h_q           <= ZERO_C;
            v_q           <= ZERO_C;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            de_q          <= 1'b0;
            pix_x_q       <= ZERO_C;
            pix_y_q       <= ZERO_C;
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
        end else begin
            sync_q        <= {sync_q[0], pll_locked};
            state_q       <= state_d;
            h_q           <= h_d;
            v_q           <= v_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            frame_start_q <= frame_start_d;
            line_start_q  <= line_start_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign frame_start = frame_start_q;
    assign line_start  = line_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen using a reduced raster so whole frames fit
// in a short run; an active-low and an active-high sync instance share all inputs.
module tb_vga_timing_gen;

    localparam int unsigned HA = 64, HF = 8, HS = 12, HB = 12;
    localparam int unsigned VA = 48, VF = 3, VS = 2, VB = 5;
    localparam int unsigned HT = HA + HF + HS + HB;   // 96
    localparam int unsigned VT = VA + VF + VS + VB;   // 58
    localparam int unsigned FR = HT * VT;             // 5568
    localparam int CW = 11;
    localparam int NV = 16;

    logic clk = 1'b0;
    logic rst;
    logic pll_locked;

    logic          hs_n, vs_n, de_n, fs_n, ls_n;
    logic [CW-1:0] x_n, y_n;
    logic          hs_p, vs_p, de_p, fs_p, ls_p;
    logic [CW-1:0] x_p, y_p;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    typedef struct {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic de, hs, vs, fs, ls;
    } exp_t;

    typedef struct {
        int unsigned   cyc;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic de, hs, vs, fs, ls;
    } vec_t;

    vec_t vecs [NV];

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(CW)
    ) dut_n (
        .refclk(clk), .rst(rst), .pll_locked(pll_locked),
        .hsync(hs_n), .vsync(vs_n), .de(de_n),
        .pix_x(x_n), .pix_y(y_n),
        .frame_start(fs_n), .line_start(ls_n)
    );

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(CW)
    ) dut_p (
        .refclk(clk), .rst(rst), .pll_locked(pll_locked),
        .hsync(hs_p), .vsync(vs_p), .de(de_p),
        .pix_x(x_p), .pix_y(y_p),
        .frame_start(fs_p), .line_start(ls_p)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input string fld, input int unsigned c,
                       input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s at c=%0d: actual %0d, required %0d", tag, fld, c, act, req);
        end
    endtask

    // Reference raster: output cycle c counted from a frame_start cycle.
    function automatic exp_t model(input int unsigned c, input logic hp, input logic vp);
        exp_t e;
        int unsigned x, y;
        x = c % HT;
        y = (c / HT) % VT;
        e.x  = CW'(x);
        e.y  = CW'(y);
        e.de = (x < HA) && (y < VA);
        e.hs = (x >= HA + HF && x < HA + HF + HS) ? hp : ~hp;
        e.vs = (y >= VA + VF && y < VA + VF + VS) ? vp : ~vp;
        e.fs = (x == 0) && (y == 0);
        e.ls = (x == 0);
        return e;
    endfunction

    task automatic check_all(input string tag, input int unsigned c);
        exp_t e, ep;
        e  = model(c, 1'b0, 1'b0);
        ep = model(c, 1'b1, 1'b1);
        chk(tag, "x",    c, 32'(x_n),  32'(e.x));
        chk(tag, "y",    c, 32'(y_n),  32'(e.y));
        chk(tag, "de",   c, 32'(de_n), 32'(e.de));
        chk(tag, "hs",   c, 32'(hs_n), 32'(e.hs));
        chk(tag, "vs",   c, 32'(vs_n), 32'(e.vs));
        chk(tag, "fs",   c, 32'(fs_n), 32'(e.fs));
        chk(tag, "ls",   c, 32'(ls_n), 32'(e.ls));
        chk(tag, "hs_p", c, 32'(hs_p), 32'(ep.hs));
        chk(tag, "vs_p", c, 32'(vs_p), 32'(ep.vs));
        chk(tag, "fs_p", c, 32'(fs_p), 32'(ep.fs));
    endtask

    task automatic check_idle(input string tag, input int unsigned c);
        chk(tag, "x",    c, 32'(x_n),  32'd0);
        chk(tag, "y",    c, 32'(y_n),  32'd0);
        chk(tag, "de",   c, 32'(de_n), 32'd0);
        chk(tag, "hs",   c, 32'(hs_n), 32'd1);
        chk(tag, "vs",   c, 32'(vs_n), 32'd1);
        chk(tag, "fs",   c, 32'(fs_n), 32'd0);
        chk(tag, "ls",   c, 32'(ls_n), 32'd0);
        chk(tag, "hs_p", c, 32'(hs_p), 32'd0);
        chk(tag, "vs_p", c, 32'(vs_p), 32'd0);
        chk(tag, "de_p", c, 32'(de_p), 32'd0);
    endtask

    initial begin
        int unsigned vi, ls_cnt, de_cnt, last_fs, last_ls, hs_len, vs_len, m;

        // Hand-computed points: hsync active x=72..83, vsync active lines 51..52.
        vecs[0]  = '{0,    11'd0,  11'd0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[1]  = '{63,   11'd63, 11'd0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{64,   11'd64, 11'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{71,   11'd71, 11'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{72,   11'd72, 11'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{83,   11'd83, 11'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{84,   11'd84, 11'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{95,   11'd95, 11'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{96,   11'd0,  11'd1,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{4575, 11'd63, 11'd47, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{4608, 11'd0,  11'd48, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{4896, 11'd0,  11'd51, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{5087, 11'd95, 11'd52, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{5088, 11'd0,  11'd53, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[14] = '{5567, 11'd95, 11'd57, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{5568, 11'd0,  11'd0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        // Reset for 4 edges with the PLL already locked.
        rst = 1'b1;
        pll_locked = 1'b1;
        repeat (4) tick();
        check_idle("reset", 0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_idle("startup", k);
        end
        tick();
        check_all("first_frame", 0);

        // Two full frames against the model, table vectors and per-frame statistics.
        vi = 0; ls_cnt = 0; de_cnt = 0; last_fs = 0; last_ls = 0; hs_len = 0; vs_len = 0;
        for (int unsigned c = 0; c <= 2 * FR; c++) begin
            if (c > 0) tick();
            check_all("sweep", c);
            if (vi < NV && vecs[vi].cyc == c) begin
                chk("table", "x",  c, 32'(x_n),  32'(vecs[vi].x));
                chk("table", "y",  c, 32'(y_n),  32'(vecs[vi].y));
                chk("table", "de", c, 32'(de_n), 32'(vecs[vi].de));
                chk("table", "hs", c, 32'(hs_n), 32'(vecs[vi].hs));
                chk("table", "vs", c, 32'(vs_n), 32'(vecs[vi].vs));
                chk("table", "fs", c, 32'(fs_n), 32'(vecs[vi].fs));
                chk("table", "ls", c, 32'(ls_n), 32'(vecs[vi].ls));
                vi++;
            end
            if (c > 0 && c % FR == 0) begin
                chk("frame", "ls_count", c, ls_cnt, VT);
                chk("frame", "de_count", c, de_cnt, HA * VA);
                ls_cnt = 0;
                de_cnt = 0;
            end
            if (fs_n === 1'b1 && c > 0) begin
                chk("frame", "fs_period", c, c - last_fs, FR);
                last_fs = c;
            end
            if (ls_n === 1'b1) begin
                if (c > 0) chk("line", "ls_period", c, c - last_ls, HT);
                last_ls = c;
                ls_cnt++;
            end
            if (de_n === 1'b1) de_cnt++;
            if (hs_n === 1'b0) begin
                if (hs_len == 0) chk("hsync", "start_x", c, 32'(x_n), HA + HF);
                hs_len++;
            end else if (hs_len != 0) begin
                chk("hsync", "width", c, hs_len, HS);
                hs_len = 0;
            end
            if (vs_n === 1'b0) begin
                if (vs_len == 0) begin
                    chk("vsync", "start_x", c, 32'(x_n), 0);
                    chk("vsync", "start_y", c, 32'(y_n), VA + VF);
                end
                vs_len++;
            end else if (vs_len != 0) begin
                chk("vsync", "width", c, vs_len, VS * HT);
                vs_len = 0;
            end
        end
        chk("table", "applied", 0, vi, NV);

        // Lock loss mid-line (y=10, x=30), then relock.
        for (m = 1; m <= 10 * HT + 30; m++) begin
            tick();
            check_all("pre_drop", m);
        end
        pll_locked = 1'b0;
        for (int unsigned k = 1; k <= 3; k++) begin
            tick();
            check_all("drop_lag", m - 1 + k);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            check_idle("unlocked", k);
        end
        pll_locked = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_idle("relock_wait", k);
        end
        tick();
        check_all("relock", 0);
        for (m = 1; m <= 20 * HT + 5; m++) begin
            tick();
            check_all("after_relock", m);
        end

        // One-cycle reset pulse mid-frame with the PLL still locked.
        rst = 1'b1;
        tick();
        check_idle("rst_pulse", 0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_idle("rst_recover", k);
        end
        tick();
        check_all("rst_restart", 0);
        for (m = 1; m <= 3 * HT; m++) begin
            tick();
            check_all("after_rst", m);
        end

        // Reset coinciding with lock loss behaves as plain reset.
        rst = 1'b1;
        pll_locked = 1'b0;
        tick();
        check_idle("rst_and_unlock", 0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_idle("held_unlocked", k);
        end
        pll_locked = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_idle("final_wait", k);
        end
        tick();
        check_all("final_restart", 0);
        for (m = 1; m <= 2 * HT; m++) begin
            tick();
            check_all("final_run", m);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
